// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, followed by a sign-fix step.
module muldiv_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MTHI,
  input  logic        MTLO,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // Op[1] selects divide, Op[0] selects unsigned.
  // Start is accepted only when the unit is IDLE; Busy=1 means Start, MTHI and MTLO are ignored.
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        fix_wb;
  logic [31:0] acc;
  logic [31:0] mq;
  logic [31:0] opnd;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic [32:0] add_sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [63:0] prod_neg;

  always_comb begin
    a_neg    = ~Op[0] & A[31];
    b_neg    = ~Op[0] & B[31];
    a_mag    = a_neg ? -A : A;
    b_mag    = b_neg ? -B : B;
    div_zero = Op[1] & (B == 32'd0);
    add_sum  = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : 33'd0);
    rem_sh   = {acc, mq[31]};
    diff     = rem_sh - {1'b0, opnd};
    prod_neg = -{acc, mq};
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      fix_wb  <= 1'b0;
      acc     <= 32'd0;
      mq      <= 32'd0;
      opnd    <= 32'd0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (div_zero) begin
              Done    <= 1'b1;
              DivZero <= 1'b1;
            end else begin
              state   <= CALC;
              Busy    <= 1'b1;
              cnt     <= 5'd0;
              fix_wb  <= 1'b0;
              is_div  <= Op[1];
              neg_res <= a_neg ^ b_neg;
              neg_rem <= Op[1] & a_neg;
              acc     <= 32'd0;
              mq      <= Op[1] ? a_mag : b_mag;
              opnd    <= Op[1] ? b_mag : a_mag;
            end
          end else begin
            if (MTHI) HI <= WData;
            if (MTLO) LO <= WData;
          end
        end
        CALC: begin
          if (is_div) begin
            // Restoring step: keep the shifted remainder when the trial subtract goes negative.
            if (!diff[32]) begin
              acc <= diff[31:0];
              mq  <= {mq[30:0], 1'b1};
            end else begin
              acc <= rem_sh[31:0];
              mq  <= {mq[30:0], 1'b0};
            end
          end else begin
            acc <= add_sum[32:1];
            mq  <= {add_sum[0], mq[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          // First FIX cycle corrects signs in the work registers, second commits to HI/LO.
          if (!fix_wb) begin
            fix_wb <= 1'b1;
            if (is_div) begin
              if (neg_res) mq  <= -mq;
              if (neg_rem) acc <= -acc;
            end else if (neg_res) begin
              acc <= prod_neg[63:32];
              mq  <= prod_neg[31:0];
            end
          end else begin
            HI    <= acc;
            LO    <= mq;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against an arithmetic reference model of HI/LO.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        divzero;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_ctrl dut (
    .Clk    (clk),
    .Reset  (reset),
    .Start  (start),
    .Op     (op),
    .A      (a),
    .B      (b),
    .MTHI   (mthi),
    .MTLO   (mtlo),
    .WData  (wdata),
    .Busy   (busy),
    .Done   (done),
    .DivZero(divzero),
    .HI     (hi),
    .LO     (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // reference model: HI/LO as MIPS defines them, from plain 64-bit arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: p = 64'(sx * sy);
      2'b01: p = {32'd0, x} * {32'd0, y};
      2'b10: begin
        q = sx / sy;
        r = sx % sy;
        p = {r[31:0], q[31:0]};
      end
      default: p = {x % y, x / y};
    endcase
    return p;
  endfunction

  task automatic check_regs(input string tag);
    check_val({tag, " hi"}, 64'(hi), 64'(m_hi));
    check_val({tag, " lo"}, 64'(lo), 64'(m_lo));
  endtask

  task automatic mt_write(input logic wr_hi, input logic wr_lo, input logic [31:0] d);
    mthi  = wr_hi;
    mtlo  = wr_lo;
    wdata = d;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    if (wr_hi) m_hi = d;
    if (wr_lo) m_lo = d;
    check_regs("mt");
  endtask

  // driver: one operation, with optional Start / MTLO pokes at a given busy cycle
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int poke_start, input int poke_mt, input logic mt_with_start);
    logic        dz;
    logic        seen_done;
    logic        overlap;
    int          busy_n;
    int          k;
    logic [63:0] want;
    dz = o[1] && (y == 32'd0);
    if (dz) exp_q.push_back({m_hi, m_lo});
    else    exp_q.push_back(ref_result(o, x, y));
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    mthi  = mt_with_start;
    mtlo  = mt_with_start;
    wdata = $urandom;
    @(negedge clk);
    start     = 1'b0;
    mthi      = 1'b0;
    mtlo      = 1'b0;
    k         = 1;
    busy_n    = 0;
    seen_done = 1'b0;
    overlap   = 1'b0;
    while (k <= 40 && !seen_done) begin
      if (busy && done) overlap = 1'b1;
      if (busy) busy_n++;
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (k == poke_start) begin
          start = 1'b1;
          op    = 2'($urandom_range(3, 0));
          a     = $urandom;
          b     = $urandom | 32'd1;
        end else begin
          start = 1'b0;
        end
        if (k == poke_mt) begin
          mtlo  = 1'b1;
          wdata = 32'hAAAA5555;
        end else begin
          mtlo = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    mtlo  = 1'b0;
    check_val("done seen", 64'(seen_done), 64'd1);
    check_val("busy cycles", 64'(busy_n), dz ? 64'd0 : 64'd34);
    check_val("done cycle", 64'(k), dz ? 64'd1 : 64'd35);
    check_val("busy and done", 64'(overlap), 64'd0);
    check_val("divzero", 64'(divzero), 64'(dz));
    want = exp_q.pop_front();
    m_hi = want[63:32];
    m_lo = want[31:0];
    check_regs("result");
    @(negedge clk);
    check_val("done pulse width", 64'(done), 64'd0);
    check_val("divzero idle", 64'(divzero), 64'd0);
  endtask

  task automatic reset_mid_op(input int at_cycle);
    start = 1'b1;
    op    = 2'b01;
    a     = $urandom;
    b     = $urandom;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < at_cycle; i++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    check_val("abort busy", 64'(busy), 64'd0);
    check_val("abort done", 64'(done), 64'd0);
    check_regs("abort");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) begin
        check_val("abort later activity", {62'd0, busy, done}, 64'd0);
        break;
      end
    end
    check_regs("abort later");
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b0;
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd3;
    b     = 32'd5;
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    reset = 1'b1;
    check_val("reset busy", 64'(busy), 64'd0);
    check_val("reset done", 64'(done), 64'd0);
    check_val("reset divzero", 64'(divzero), 64'd0);
    check_regs("reset");

    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 1'b0);
    check_val("mult hi const", 64'(hi), 64'hFFFF_FFFF);
    check_val("mult lo const", 64'(lo), 64'hFFFF_FFFE);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 1'b0);
    check_val("multu hi const", 64'(hi), 64'h0000_0001);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
    check_val("div lo const", 64'(lo), 64'hFFFF_FFFD);
    check_val("div hi const", 64'(hi), 64'hFFFF_FFFF);

    mt_write(1'b1, 1'b0, 32'h1234_5678);
    run_op(2'b11, 32'd5, 32'd0, 0, 0, 1'b0);
    check_val("divzero hi kept", 64'(hi), 64'h1234_5678);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 11, 0, 1'b0);
    check_val("overflow lo", 64'(lo), 64'h8000_0000);
    check_val("overflow hi", 64'(hi), 64'h0);

    reset_mid_op(16);
    run_op(2'b01, 32'd7, 32'd9, 0, 0, 1'b0);

    run_op(2'b00, 32'hFFFF_FF00, 32'h0001_2345, 0, 6, 1'b0);
    mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
    run_op(2'b10, 32'd100, 32'hFFFF_FFFD, 0, 0, 1'b1);

    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom_range(3, 0));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(5, 0) == 0) rb = 32'd0;
      else if ($urandom_range(3, 0) == 0) rb = 32'($urandom_range(16, 1));
      if ($urandom_range(3, 0) == 0) ra = 32'($urandom_range(200, 0));
      if ($urandom_range(4, 0) == 0)
        mt_write(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom);
      run_op(ro, ra, rb, int'($urandom_range(30, 0)), int'($urandom_range(30, 0)),
             1'($urandom_range(1, 0)));
    end

    check_val("queue empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
